// File: rtl/branch_predictor_if.sv
// Fetch/execute interface of the branch predictor: IF lookup bus plus EX resolve bus.
// The pipeline drives it through the master modport and the predictor through the slave modport.
interface branch_predictor_if;
  logic [31:0] PC_IF;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_br_valid;
  logic [31:0] PC_EX;
  logic        br;
  logic [31:0] br_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        mispredict;
  logic [31:0] correct_pc;

  modport master (
    output PC_IF, ex_br_valid, PC_EX, br, br_target, ex_pred_taken, ex_pred_pc,
    input  pred_taken, pred_pc, mispredict, correct_pc
  );

  modport slave (
    input  PC_IF, ex_br_valid, PC_EX, br, br_target, ex_pred_taken, ex_pred_pc,
    output pred_taken, pred_pc, mispredict, correct_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT: zero-latency combinational predict/resolve, table write on clk.
// No backpressure (caller owns stalls); BRANCH_PREDICTOR_PERF_EN adds br_cnt/miss_cnt counters.
module branch_predictor #(
  parameter int         ENTRY_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter logic [1:0] CNT_ALLOC  = 2'b10
) (
  input  logic clk,
  input  logic rst_n,
  branch_predictor_if.slave bp
`ifdef BRANCH_PREDICTOR_PERF_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 30 - ENTRY_BITS;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];

  logic [ENTRY_BITS-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0]      tag_if, tag_ex;
  logic                  hit_if, hit_ex, pred_taken, mispredict;
  logic                  unused_pc_bits;

  assign idx_if = bp.PC_IF[ENTRY_BITS+1:2];
  assign tag_if = bp.PC_IF[31:ENTRY_BITS+2];
  assign idx_ex = bp.PC_EX[ENTRY_BITS+1:2];
  assign tag_ex = bp.PC_EX[31:ENTRY_BITS+2];
  assign unused_pc_bits = ^{bp.PC_IF[1:0], bp.PC_EX[1:0]};

  // Reads see pre-edge table contents only; a same-cycle update is not bypassed.
  assign hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign pred_taken    = hit_if && cnt_q[idx_if][1];
  assign bp.pred_taken = pred_taken;
  assign bp.pred_pc    = pred_taken ? target_q[idx_if] : bp.PC_IF + 32'd4;

  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
  assign mispredict = bp.ex_br_valid &&
                      (bp.br ? (!bp.ex_pred_taken || (bp.ex_pred_pc != bp.br_target))
                             : bp.ex_pred_taken);
  assign bp.mispredict = mispredict;
  assign bp.correct_pc = bp.br ? bp.br_target : bp.PC_EX + 32'd4;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (bp.ex_br_valid) begin
      if (bp.br) begin
        if (hit_ex) begin
          target_d[idx_ex] = bp.br_target;
          cnt_d[idx_ex]    = (cnt_q[idx_ex] == 2'b11) ? 2'b11 : cnt_q[idx_ex] + 2'd1;
        end else begin
          // Miss on a taken branch allocates, evicting any aliased entry.
          valid_d[idx_ex]  = 1'b1;
          tag_d[idx_ex]    = tag_ex;
          target_d[idx_ex] = bp.br_target;
          cnt_d[idx_ex]    = CNT_ALLOC;
        end
      end else if (hit_ex) begin
        cnt_d[idx_ex] = (cnt_q[idx_ex] == 2'b00) ? 2'b00 : cnt_q[idx_ex] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bp.ex_br_valid) br_cnt_d = br_cnt_q + 32'd1;
    if (mispredict)     miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations queued as each step is driven,
// drained and asserted at the following falling edge (or mid-cycle around async reset).
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if bif ();
`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] br_cnt, miss_cnt;
`endif

  branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bif)
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    .br_cnt   (br_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0: return {31'd0, bif.pred_taken};
      1: return bif.pred_pc;
      2: return {31'd0, bif.mispredict};
      3: return bif.correct_pc;
`ifdef BRANCH_PREDICTOR_PERF_EN
      4: return br_cnt;
      5: return miss_cnt;
`endif
      default: return 'x;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pred(string tag, logic t, logic [31:0] pc);
    push({tag, ".pred_taken"}, 0, {31'd0, t});
    push({tag, ".pred_pc"}, 1, pc);
  endtask

  task automatic resolve(string tag, logic m, logic [31:0] cpc);
    push({tag, ".mispredict"}, 2, {31'd0, m});
    if (m) push({tag, ".correct_pc"}, 3, cpc);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_now();
  endtask

  task automatic cyc(logic [31:0] pc_if, logic v, logic [31:0] pc_ex, logic b,
                     logic [31:0] tgt, logic ept, logic [31:0] epc);
    @(posedge clk);
    #1;
    bif.PC_IF         = pc_if;
    bif.ex_br_valid   = v;
    bif.PC_EX         = pc_ex;
    bif.br            = b;
    bif.br_target     = tgt;
    bif.ex_pred_taken = ept;
    bif.ex_pred_pc    = epc;
  endtask

  task automatic idle(logic [31:0] pc_if);
    cyc(pc_if, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic brx(logic [31:0] pc_if, logic [31:0] pc_ex, logic b, logic [31:0] tgt,
                     logic ept, logic [31:0] epc);
    cyc(pc_if, 1'b1, pc_ex, b, tgt, ept, epc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    bif.PC_IF         = 32'h100;
    bif.ex_br_valid   = 1'b0;
    bif.PC_EX         = 32'd0;
    bif.br            = 1'b0;
    bif.br_target     = 32'd0;
    bif.ex_pred_taken = 1'b0;
    bif.ex_pred_pc    = 32'd0;
    #2;
    pred("in_reset", 1'b0, 32'h104);
    resolve("in_reset", 1'b0, 32'd0);
    check_now();
    #10;
    rst_n = 1'b1;

    brx(32'h100, 32'h100, 1'b0, 32'h500, 1'b0, 32'h104);
    pred("nt_miss", 1'b0, 32'h104); resolve("nt_miss", 1'b0, 32'd0); sample();
    idle(32'h100);
    pred("nt_noalloc", 1'b0, 32'h104); resolve("idle", 1'b0, 32'd0); sample();

    brx(32'h200, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
    pred("alloc_same_cycle", 1'b0, 32'h204); resolve("alloc", 1'b1, 32'h80); sample();
    idle(32'h200);
    pred("alloc_hit", 1'b1, 32'h80); sample();

    // Counter walk: 2 -> 3 -> 3 -> 3 -> 2 -> 1 -> 0 -> 1 -> 2.
    brx(32'h200, 32'h200, 1'b1, 32'h80, 1'b1, 32'h80);
    pred("tk1", 1'b1, 32'h80); resolve("tk1", 1'b0, 32'd0); sample();
    brx(32'h200, 32'h200, 1'b1, 32'h80, 1'b1, 32'h80);
    resolve("tk2", 1'b0, 32'd0); sample();
    brx(32'h200, 32'h200, 1'b1, 32'h80, 1'b1, 32'h84);
    resolve("tk3_bad_target", 1'b1, 32'h80); sample();
    brx(32'h200, 32'h200, 1'b0, 32'h80, 1'b1, 32'h80);
    pred("nt1", 1'b1, 32'h80); resolve("nt1", 1'b1, 32'h204); sample();
    brx(32'h200, 32'h200, 1'b0, 32'h80, 1'b1, 32'h80);
    pred("nt2", 1'b1, 32'h80); resolve("nt2", 1'b1, 32'h204); sample();
    idle(32'h200);
    pred("after_nt2", 1'b0, 32'h204); sample();
    brx(32'h200, 32'h200, 1'b0, 32'h80, 1'b0, 32'h204);
    resolve("nt3", 1'b0, 32'd0); sample();
    brx(32'h200, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
    resolve("tk_from_zero", 1'b1, 32'h80); sample();
    idle(32'h200);
    pred("cnt_one", 1'b0, 32'h204); sample();
    brx(32'h200, 32'h200, 1'b1, 32'h90, 1'b0, 32'h204);
    resolve("retarget", 1'b1, 32'h90); sample();
    idle(32'h200);
    pred("retarget_hit", 1'b1, 32'h90); sample();

    // 0x200 and 0x300 share index 0 with different tags.
    brx(32'h300, 32'h300, 1'b1, 32'h40, 1'b0, 32'h304);
    pred("alias_pre", 1'b0, 32'h304); resolve("alias_alloc", 1'b1, 32'h40); sample();
    idle(32'h200);
    pred("alias_old_miss", 1'b0, 32'h204); sample();
    idle(32'h300);
    pred("alias_new_hit", 1'b1, 32'h40); sample();
    brx(32'h500, 32'h200, 1'b0, 32'h80, 1'b0, 32'h204);
    pred("miss_500", 1'b0, 32'h504); resolve("alias_nt", 1'b0, 32'd0); sample();
    idle(32'h300);
    pred("alias_keep", 1'b1, 32'h40); sample();
    idle(32'hFFFF_FFFC);
    pred("wrap", 1'b0, 32'h0); sample();

    brx(32'h400, 32'h400, 1'b1, 32'h10, 1'b0, 32'h404);
    pred("hazard_same", 1'b0, 32'h404); resolve("hazard", 1'b1, 32'h10); sample();
    idle(32'h400);
    pred("hazard_next", 1'b1, 32'h10); sample();

    // Reset lands while a taken update for 0x600 is pending and stays over the edge.
    brx(32'h400, 32'h600, 1'b1, 32'h20, 1'b0, 32'h604);
    pred("pre_rst", 1'b1, 32'h10); check_now();
    #2;
    rst_n = 1'b0;
    #1;
    pred("rst_async", 1'b0, 32'h404); check_now();
    @(posedge clk);
    #1;
    bif.ex_br_valid = 1'b0;
    rst_n = 1'b1;
    idle(32'h400);
    pred("rst_clr_400", 1'b0, 32'h404); sample();
    idle(32'h600);
    pred("rst_abort_600", 1'b0, 32'h604); sample();
    idle(32'h300);
    pred("rst_clr_300", 1'b0, 32'h304); sample();
    brx(32'h600, 32'h600, 1'b1, 32'h20, 1'b0, 32'h604);
    resolve("post_rst_alloc", 1'b1, 32'h20); sample();
    idle(32'h600);
    pred("post_rst_hit", 1'b1, 32'h20); sample();

`ifdef BRANCH_PREDICTOR_PERF_EN
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      brx(32'h700, 32'h1000 + 32'(i * 16), 1'b0, 32'd0, (i < 3), 32'd0);
      resolve("perf_br", (i < 3), 32'h1004 + 32'(i * 16)); sample();
    end
    idle(32'h700);
    push("perf.br_cnt", 4, 32'd10);
    push("perf.miss_cnt", 5, 32'd3);
    sample();
    @(posedge clk);
    #1;
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_q;
    brx(32'h700, 32'h2000, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(32'h700);
    push("perf.br_cnt_wrap", 4, 32'd0);
    push("perf.miss_cnt_hold", 5, 32'd3);
    sample();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the EX-stage branch decision logic. In IF it predicts the next PC from a direct-mapped BTB plus a 2-bit BHT.
- In EX it takes the resolved outcome (`br`, `br_target`), trains the tables and flags mispredictions so the hazard unit can flush IF/ID and redirect the PC.
- Reads are combinational. Writes are clocked.

Parameters:
- ENTRY_BITS, 6, log2 of table entries (64). Index = PC[ENTRY_BITS+1:2]; tag = PC[31:ENTRY_BITS+2].
- CNT_INIT, 2'b01, BHT counter value after reset (weakly not-taken).
- CNT_ALLOC, 2'b10, BHT counter value written when a new entry is allocated (weakly taken).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- PC_IF  input  32  PC being fetched.
- pred_taken  output  1  prediction for PC_IF: taken.
- pred_pc  output  32  next fetch PC: predicted target if pred_taken, else PC_IF+4.
- ex_br_valid  input  1  EX stage holds a conditional branch; high one cycle per branch, already gated by stall/bubble.
- PC_EX  input  32  PC of the EX branch.
- br  input  1  resolved outcome from branch decision.
- br_target  input  32  resolved branch target.
- ex_pred_taken  input  1  pred_taken piped alongside the branch from IF to EX.
- ex_pred_pc  input  32  pred_pc piped alongside the branch from IF to EX.
- mispredict  output  1  EX branch was mispredicted; flush IF/ID and redirect.
- correct_pc  output  32  redirect PC: br ? br_target : PC_EX+4.

Behaviour:
- State per entry: valid (1), tag (32-ENTRY_BITS-2), target (32), cnt (2).
- Reset (async on rst_n low; asserting it mid-operation aborts any pending update):
  - every valid cleared and every cnt set to CNT_INIT; tag and target are don't-care.
  - pred_taken=0 and pred_pc=PC_IF+4 while rst_n is low and until the first allocation.
- Predict (combinational, zero latency):
  - hit = valid[idx_IF] & (tag[idx_IF]==tag_IF).
  - pred_taken = hit & cnt[idx_IF][1].
  - pred_pc = pred_taken ? target[idx_IF] : PC_IF+4. Addition wraps mod 2^32; 0xFFFFFFFC+4 = 0.
- Resolve (combinational, same cycle as ex_br_valid):
  - mispredict = ex_br_valid & (br ? (!ex_pred_taken | ex_pred_pc!=br_target) : ex_pred_taken).
  - mispredict=0 whenever ex_br_valid=0.
  - correct_pc is always driven; it is only meaningful when mispredict=1.
- Update, on the rising clk edge when ex_br_valid=1. hit_EX is computed on idx/tag of PC_EX.
  - br=1, hit_EX=1: target<=br_target; cnt saturating increment (3 stays 3).
  - br=1, hit_EX=0: allocate or replace the entry: valid<=1, tag<=tag_EX, target<=br_target, cnt<=CNT_ALLOC.
  - br=0, hit_EX=1: cnt saturating decrement (0 stays 0); tag and target unchanged.
  - br=0, hit_EX=0: no state change (no allocation on not-taken).
  - ex_br_valid=0: no state change.
- Same index read/written in one cycle: the IF read returns the pre-edge contents, with no bypass. The new value is visible from the next cycle.
- Aliasing: a tag mismatch counts as a miss. A taken branch overwrites the aliased entry.
- Pipeline stall is the caller's responsibility. ex_br_valid must be high for exactly one cycle per branch, even across stalls.

Optional Feature:
- Macro: BRANCH_PREDICTOR_PERF_EN.
- Defined: adds output br_cnt [31:0] and output miss_cnt [31:0].
  - br_cnt increments on each clk edge with ex_br_valid=1.
  - miss_cnt increments on each clk edge with mispredict=1.
  - Both reset to 0 asynchronously and wrap 0xFFFFFFFF -> 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then PC_IF=0x100 -> pred_taken=0, pred_pc=0x104. Pulse ex_br_valid with br=0 at PC_EX=0x100 -> mispredict=0, no allocation, prediction unchanged.
- Taken branch at PC_EX=0x200 to 0x80, with ex_pred_taken=0 -> mispredict=1, correct_pc=0x80. Next cycle PC_IF=0x200 -> pred_taken=1, pred_pc=0x80.
- Same branch resolved taken 3 more times, then not-taken twice -> cnt walks 2→3→3→3→2→1. pred_taken goes to 0 after the second not-taken. A not-taken with ex_pred_taken=1 -> mispredict=1, correct_pc=0x204.
- Alias (ENTRY_BITS=6): taken at 0x200 to 0x80, then taken at 0x300 to 0x40 (same index 0) -> PC_IF=0x200 misses (pred_pc=0x204); PC_IF=0x300 hits with pred_pc=0x40.
- Same-cycle hazard: PC_IF=0x400 and update for 0x400 to 0x10 in the same cycle -> that cycle pred_pc=0x404; the following cycle pred_pc=0x10. Assert rst_n low mid-sequence -> immediate pred_taken=0 and all entries cleared.
- With BRANCH_PREDICTOR_PERF_EN: 10 branches, 3 mispredicted -> br_cnt=10, miss_cnt=3. Preload br_cnt=0xFFFFFFFF via force, then one branch -> 0.
